// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-coin, multi-product vending controller with unit-pulse change return
module vending_machine_multi #(
  parameter int NUM_COINS = 2,
  parameter int CREDIT_W = 12,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = {12'd150, 12'd100},
  parameter int NUM_PROD = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {12'd100, 12'd150, 12'd250, 12'd200},
  parameter int MAX_CREDIT = 1000,
  parameter int CHANGE_UNIT = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_COINS-1:0]        coin,
  input  logic                        sel_valid,
  input  logic [$clog2(NUM_PROD)-1:0] sel_id,
  input  logic                        cancel,
  output logic                        dispense,
  output logic [$clog2(NUM_PROD)-1:0] dispense_id,
  output logic                        change,
  output logic                        coin_reject,
  output logic                        sel_denied,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        busy
);
  localparam int SW = $clog2(NUM_PROD);
  localparam logic [CREDIT_W:0] MAX = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);
  for (genvar i = 0; i < NUM_COINS; i++) begin : g_coin_chk
    localparam int v = int'(COIN_VALUES[i*CREDIT_W +: CREDIT_W]);
    if (v == 0 || v > MAX_CREDIT || v % CHANGE_UNIT != 0) begin : g_bad
      $error("invalid coin value %0d", v);
    end
  end
  for (genvar i = 0; i < NUM_PROD; i++) begin : g_price_chk
    localparam int v = int'(PRICES[i*CREDIT_W +: CREDIT_W]);
    if (v == 0 || v > MAX_CREDIT || v % CHANGE_UNIT != 0) begin : g_bad
      $error("invalid price %0d", v);
    end
  end
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, coin_val, price;
  logic [CREDIT_W:0] sum;
  logic [SW-1:0] id_n;
  logic disp_n, chg_n, rej_n, den_n, sel_in;
  always_comb begin
    coin_val = '0;
    price = '0;
    sel_in = 1'b0;
    for (int i = 0; i < NUM_COINS; i++)
      coin_val = coin[i] ? coin_val | COIN_VALUES[i*CREDIT_W +: CREDIT_W] : coin_val;
    for (int i = 0; i < NUM_PROD; i++) begin
      price = (sel_id == SW'(i)) ? PRICES[i*CREDIT_W +: CREDIT_W] : price;
      sel_in = sel_in | (sel_id == SW'(i));
    end
    sum = {1'b0, credit} + {1'b0, coin_val};
    state_n = state;
    credit_n = credit;
    id_n = dispense_id;
    disp_n = 1'b0;
    chg_n = 1'b0;
    rej_n = 1'b0;
    den_n = 1'b0;
    if (state == VEND || state == CHANGE) begin
      rej_n = coin != '0;
      den_n = sel_valid;
      chg_n = credit != '0;
      state_n = credit != '0 ? CHANGE : IDLE;
      credit_n = credit != '0 ? credit - UNIT : credit;
    end else if (cancel && credit != '0) begin
      rej_n = coin != '0;
      chg_n = 1'b1;
      state_n = CHANGE;
      credit_n = credit - UNIT;
    end else if (sel_valid) begin
      rej_n = coin != '0;
      if (sel_in && price <= credit) begin
        disp_n = 1'b1;
        id_n = sel_id;
        state_n = VEND;
        credit_n = credit - price;
      end else begin
        den_n = 1'b1;
      end
    end else if (coin != '0) begin
      if ($onehot(coin) && sum <= MAX) begin
        credit_n = sum[CREDIT_W-1:0];
        state_n = CREDIT;
      end else begin
        rej_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      dispense_id <= '0;
      dispense <= 1'b0;
      change <= 1'b0;
      coin_reject <= 1'b0;
      sel_denied <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      dispense_id <= id_n;
      dispense <= disp_n;
      change <= chg_n;
      coin_reject <= rej_n;
      sel_denied <= den_n;
    end
  end
  assign busy = state == VEND || state == CHANGE;
endmodule
